cic_decim_strobe_ctrl: RTL and testbench

Rate controller for the CIC decimator. Counts accepted input samples, generates the one-cycle output-rate strobe that drives the decimator's comb section (`act_out_i`), and applies a runtime-programmable decimation ratio only at frame boundaries. It re-aligns the frame on an external sync pulse. It suppresses the output valid for a warm-up period after reset, after a ratio change and after a sync, so that no unsettled comb output reaches downstream stages.

---
 rtl/cic_decim_strobe_ctrl.sv | 123 ++++++++++++
 tb/tb_cic_decim_strobe_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cic_decim_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cic_decim_strobe_ctrl
// Description : Rate controller for the CIC decimator. Counts accepted input
//               samples and raises the output-rate strobe for the comb section.
//               A new decimation ratio takes effect only at a frame start.
//               An external sync pulse re-aligns the frame. Output valid is
//               suppressed for WARMUP strobes after reset, after a ratio change
//               and after a sync.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        : clock
//   rst_i        : asynchronous active-high reset
//   en_i         : global clock enable; all state holds while low
//   act_i        : input sample strobe
//   ratio_i      : requested decimation ratio (0 and 1 both mean 1)
//   sync_i       : frame re-alignment pulse
//   act_out_o    : output-rate strobe to the decimator's comb section
//   val_o        : qualifies the decimator's data output
//   warm_o       : high while the warm-up count is incomplete
//   ratio_cur_o  : ratio in force for the current frame
// ============================================================================
module cic_decim_strobe_ctrl #(
  parameter int RATE_WIDTH = 8,
  parameter int WARMUP     = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  act_i,
  input  logic [RATE_WIDTH-1:0] ratio_i,
  input  logic                  sync_i,
  output logic                  act_out_o,
  output logic                  val_o,
  output logic                  warm_o,
  output logic [RATE_WIDTH-1:0] ratio_cur_o
);

  localparam int                    WCNT_W     = 8;
  localparam logic [WCNT_W-1:0]     c_warmup   = WCNT_W'(WARMUP);
  localparam logic [WCNT_W-1:0]     c_wcnt_one = WCNT_W'(1);
  localparam logic [RATE_WIDTH-1:0] c_one      = RATE_WIDTH'(1);

  logic [RATE_WIDTH-1:0] r_cnt;
  logic [RATE_WIDTH-1:0] r_ratio_q;
  logic [WCNT_W-1:0]     r_wcnt;
  logic                  r_act_out;
  logic                  r_val;

  logic                  w_accept;
  logic                  w_sync;
  logic                  w_frame_start;
  logic [RATE_WIDTH-1:0] w_eff_raw;
  logic [RATE_WIDTH-1:0] w_eff;
  logic [RATE_WIDTH-1:0] w_cnt_base;
  logic                  w_wrap;
  logic                  w_req;
  logic                  w_load;
  logic                  w_ratio_chg;
  logic                  w_warm_clr;
  logic                  w_warm_done;

  assign w_accept      = en_i & act_i;
  assign w_sync        = en_i & sync_i;

  // A sync makes the current sample the first of a fresh frame, so the frame
  // start and the counter base behave as if cnt were already zero.
  assign w_frame_start = w_sync | (r_cnt == '0);
  assign w_cnt_base    = w_sync ? '0 : r_cnt;

  // Ratio is sampled from the input only at a frame start; 0 is treated as 1.
  assign w_eff_raw     = w_frame_start ? ratio_i : r_ratio_q;
  assign w_eff         = (w_eff_raw == '0) ? c_one : w_eff_raw;

  assign w_wrap        = (w_cnt_base == (w_eff - c_one));
  assign w_req         = w_accept & w_wrap;
  assign w_load        = w_accept & w_frame_start;

  // r_ratio_q is 0 only after reset, so the first load always restarts warm-up.
  assign w_ratio_chg   = w_load & (w_eff != r_ratio_q);
  assign w_warm_clr    = w_sync | w_ratio_chg;
  assign w_warm_done   = (r_wcnt == c_warmup);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_ratio_q <= '0;
      r_wcnt    <= '0;
      r_act_out <= 1'b0;
      r_val     <= 1'b0;
    end else if (en_i) begin
      if (w_accept) begin
        r_cnt <= w_wrap ? '0 : (w_cnt_base + c_one);
      end else if (w_sync) begin
        r_cnt <= '0;
      end

      if (w_load) begin
        r_ratio_q <= w_eff;
      end

      // A clear wins over a strobe consumed in the same cycle.
      if (w_warm_clr) begin
        r_wcnt <= '0;
      end else if (r_act_out && !w_warm_done) begin
        r_wcnt <= r_wcnt + c_wcnt_one;
      end

      // With en_i high any pending strobe is consumed this cycle, so the
      // strobe register simply follows the new request.
      r_act_out <= w_req;
      r_val     <= r_act_out & w_warm_done;
    end
  end

  assign act_out_o   = r_act_out;
  assign val_o       = r_val;
  assign warm_o      = ~w_warm_done;
  assign ratio_cur_o = r_ratio_q;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_strobe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decim_strobe_ctrl
// Description : Self-checking bench for cic_decim_strobe_ctrl (WARMUP = 3).
//               Cycle vectors with expected outputs are queued as they are
//               driven and compared against the DUT on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decim_strobe_ctrl;

  logic       clk_i;
  logic       rst_i;
  logic       en_i;
  logic       act_i;
  logic [7:0] ratio_i;
  logic       sync_i;
  logic       act_out_o;
  logic       val_o;
  logic       warm_o;
  logic [7:0] ratio_cur_o;

  cic_decim_strobe_ctrl #(
    .RATE_WIDTH (8),
    .WARMUP     (3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .act_i       (act_i),
    .ratio_i     (ratio_i),
    .sync_i      (sync_i),
    .act_out_o   (act_out_o),
    .val_o       (val_o),
    .warm_o      (warm_o),
    .ratio_cur_o (ratio_cur_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst_before;
    logic       en;
    logic       act;
    logic       sync;
    logic [7:0] ratio;
    logic       exp_act;
    logic       exp_val;
    logic       exp_warm;
    logic [7:0] exp_ratio;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic rb, input logic en, input logic act,
                     input logic sy, input logic [7:0] r, input logic ea,
                     input logic ev, input logic ew, input logic [7:0] er);
    vec_t v;
    v = '{rb, en, act, sy, r, ea, ev, ew, er};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s [vec %0d]: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic chk_reset_state(input int idx);
    chk("rst act_out_o", idx, {7'd0, act_out_o}, 8'd0);
    chk("rst val_o", idx, {7'd0, val_o}, 8'd0);
    chk("rst warm_o", idx, {7'd0, warm_o}, 8'd1);
    chk("rst ratio_cur_o", idx, ratio_cur_o, 8'd0);
  endtask

  // Called right after a rising edge; reset is pulsed between edges.
  task automatic do_reset(input int idx);
    rst_i = 1'b1;
    #2;
    chk_reset_state(idx);
    rst_i = 1'b0;
  endtask

  initial begin
    vec_t e;
    rst_i   = 1'b1;
    en_i    = 1'b0;
    act_i   = 1'b0;
    sync_i  = 1'b0;
    ratio_i = 8'd0;

    // Ratio 4, steady rate.
    for (int c = 0; c <= 22; c++)
      add(c == 0, 1'b1, 1'b1, 1'b0, 8'd4,
          c inside {4, 8, 12, 16, 20}, (c == 17) || (c == 21), c < 13,
          (c == 0) ? 8'd0 : 8'd4);
    // Mid-frame ratio change 4 -> 6 at cycle 2.
    for (int c = 0; c <= 30; c++)
      add(c == 0, 1'b1, 1'b1, 1'b0, (c < 2) ? 8'd4 : 8'd6,
          c inside {4, 10, 16, 22, 28}, c == 29, c < 23,
          (c == 0) ? 8'd0 : ((c <= 4) ? 8'd4 : 8'd6));
    // Sync with a coincident sample at cycle 6.
    for (int c = 0; c <= 24; c++)
      add(c == 0, 1'b1, 1'b1, c == 6, 8'd4,
          c inside {4, 10, 14, 18, 22}, c == 23, c < 19,
          (c == 0) ? 8'd0 : 8'd4);
    // Ratio 2 with en_i low for cycles 2..4 while the strobe is pending.
    for (int c = 0; c <= 13; c++)
      add(c == 0, !((c >= 2) && (c <= 4)), 1'b1, 1'b0, 8'd2,
          c inside {2, 3, 4, 5, 7, 9, 11, 13}, c == 12, c < 10,
          (c == 0) ? 8'd0 : 8'd2);
    // Ratio 0 behaves as ratio 1.
    for (int c = 0; c <= 7; c++)
      add(c == 0, 1'b1, 1'b1, 1'b0, 8'd0,
          c >= 1, c >= 5, c < 4, (c == 0) ? 8'd0 : 8'd1);

    @(posedge clk_i);
    #1;
    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset(i);
      en_i    = vecs[i].en;
      act_i   = vecs[i].act;
      sync_i  = vecs[i].sync;
      ratio_i = vecs[i].ratio;
      sb.push_back(vecs[i]);
      @(negedge clk_i);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard [vec %0d]: got empty queue, expected entry", i);
      end else begin
        e = sb.pop_front();
        chk("act_out_o", i, {7'd0, act_out_o}, {7'd0, e.exp_act});
        chk("val_o", i, {7'd0, val_o}, {7'd0, e.exp_val});
        chk("warm_o", i, {7'd0, warm_o}, {7'd0, e.exp_warm});
        chk("ratio_cur_o", i, ratio_cur_o, e.exp_ratio);
      end
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset mid-stream while the ratio-1 stream is running.
    @(negedge clk_i);
    chk("pre-rst act_out_o", 1000, {7'd0, act_out_o}, 8'd1);
    chk("pre-rst val_o", 1000, {7'd0, val_o}, 8'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_state(1001);
    @(posedge clk_i);
    #1;
    chk_reset_state(1002);

    // Released with en_i low: nothing may move.
    en_i  = 1'b0;
    #2;
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_state(1003);

    // One enabled sample loads the normalised ratio and requests a strobe.
    en_i = 1'b1;
    @(posedge clk_i);
    #1;
    en_i = 1'b0;
    chk("post act_out_o", 1004, {7'd0, act_out_o}, 8'd1);
    chk("post ratio_cur_o", 1004, ratio_cur_o, 8'd1);
    chk("post warm_o", 1004, {7'd0, warm_o}, 8'd1);
    @(posedge clk_i);
    #1;
    chk("held act_out_o", 1005, {7'd0, act_out_o}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
